// File: rtl/fprint_registers_nmr.sv
// Fingerprint register/buffer block for N-modular-redundant task comparison:
// ingress FIFO, per-task checkout/checkin state and one circular buffer per logical core.
module fprint_registers_nmr #(
  parameter int unsigned NUM_CORES  = 3,
  parameter int unsigned CORE_ID_W  = 2,
  parameter int unsigned NUM_TASKS  = 16,
  parameter int unsigned RAM_DEPTH  = 16,
  parameter int unsigned PTR_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  CS_OFFSET  = 4'h0,
  parameter logic [3:0]  CRC_OFFSET = 4'h1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 fprint_address,
  input  logic                       fprint_write,
  input  logic [31:0]                fprint_writedata,
  output logic                       fprint_waitrequest,
  output logic [3:0]                 fprint_physical_core_id,
  output logic [3:0]                 fprint_task_id,
  input  logic [CORE_ID_W-1:0]       fprint_logical_core_id,
  input  logic [NUM_CORES-1:0]       fprint_nmr_mask,
  input  logic [NUM_CORES*PTR_W-1:0] comp_tail_pointer,
  output logic [NUM_CORES*32-1:0]    fprint_rd_data,
  output logic                       fprint_count_inc,
  output logic [CORE_ID_W-1:0]       fprint_count_core,
  output logic [NUM_CORES-1:0]       fprint_overflow,
  input  logic [NUM_CORES-1:0]       fprint_overflow_clear,
  input  logic [3:0]                 comparator_task_id,
  input  logic                       fprint_reset_task,
  output logic                       fprint_reset_task_ack,
  output logic [NUM_TASKS-1:0]       fprint_checkin
);

  localparam int unsigned ENT_W  = 30;
  localparam int unsigned FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = FPTR_W + 1;

  typedef enum logic {I_IDLE, I_PUSH} istate_t;
  typedef enum logic [2:0] {IDLE, CLR, ACK, POP, DECODE, REG_WR, MEM_WR, COUNT} state_t;

  istate_t istate;
  state_t  state;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [FPTR_W-1:0] fifo_wr, fifo_rd;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ENT_W-1:0]  fifo_head;

  logic [15:0]          cur_half;
  logic [3:0]           cur_region;
  logic                 cur_hi, cur_cs;
  logic [CORE_ID_W-1:0] cur_core;

  logic [NUM_TASKS-1:0] checkout [NUM_CORES];
  logic [NUM_TASKS-1:0] checkin  [NUM_CORES];
  logic [PTR_W-1:0]     head     [NUM_CORES];
  logic [15:0]          mem_lo   [NUM_CORES][RAM_DEPTH];
  logic [15:0]          mem_hi   [NUM_CORES][RAM_DEPTH];

  logic [CORE_ID_W-1:0] core_sel;
  logic [NUM_CORES-1:0] core_onehot;
  logic                 core_valid;
  logic [NUM_TASKS-1:0] sel_checkout;
  logic [PTR_W-1:0]     sel_head, sel_tail, head_inc;
  logic                 buf_full;
  logic [NUM_TASKS-1:0] checkin_vote;
  logic                 unused_wd;

  assign unused_wd  = ^fprint_writedata[15:6];
  assign fifo_full  = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign fifo_push  = (istate == I_PUSH);
  assign fifo_pop   = (state == POP);
  assign fifo_head  = fifo_mem[fifo_rd];

  // Ingress handshake: one accepted write per I_PUSH cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      istate             <= I_IDLE;
      fprint_waitrequest <= 1'b1;
    end else begin
      case (istate)
        I_IDLE: if (fprint_write && !fifo_full) begin
          istate             <= I_PUSH;
          fprint_waitrequest <= 1'b0;
        end
        I_PUSH: begin
          istate             <= I_IDLE;
          fprint_waitrequest <= 1'b1;
        end
        default: istate <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) fifo_wr <= fifo_wr + FPTR_W'(1);
      if (fifo_pop)  fifo_rd <= fifo_rd + FPTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wr] <= {fprint_writedata[31:16], fprint_address, fprint_writedata[5:0]};
  end

  // Per-core selection: the live logical id while decoding, the latched one afterwards
  always_comb begin
    core_sel     = (state == DECODE) ? fprint_logical_core_id : cur_core;
    core_onehot  = '0;
    core_valid   = 1'b0;
    sel_checkout = '0;
    sel_head     = '0;
    sel_tail     = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (core_sel == CORE_ID_W'(c)) begin
        core_onehot[c] = 1'b1;
        core_valid     = 1'b1;
        sel_checkout   = checkout[c];
        sel_head       = head[c];
        sel_tail       = comp_tail_pointer[c*PTR_W +: PTR_W];
      end
    end
  end

  assign head_inc = sel_head + PTR_W'(1);
  assign buf_full = (head_inc == sel_tail);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      fprint_physical_core_id <= '0;
      fprint_task_id          <= '0;
      fprint_count_inc        <= 1'b0;
      fprint_count_core       <= '0;
      fprint_overflow         <= '0;
      fprint_reset_task_ack   <= 1'b0;
      cur_half                <= '0;
      cur_region              <= '0;
      cur_hi                  <= 1'b0;
      cur_cs                  <= 1'b0;
      cur_core                <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        checkout[c] <= '0;
        checkin[c]  <= '0;
        head[c]     <= '0;
      end
    end else begin
      fprint_count_inc      <= 1'b0;
      fprint_reset_task_ack <= 1'b0;
      fprint_overflow       <= fprint_overflow & ~fprint_overflow_clear;
      case (state)
        IDLE: begin
          if (fprint_reset_task)  state <= CLR;
          else if (!fifo_empty)   state <= POP;
        end
        CLR: begin
          for (int c = 0; c < NUM_CORES; c++) begin
            checkout[c][comparator_task_id] <= 1'b0;
            checkin[c][comparator_task_id]  <= 1'b0;
          end
          fprint_reset_task_ack <= 1'b1;
          state                 <= ACK;
        end
        ACK: state <= IDLE;
        POP: begin
          cur_half                <= fifo_head[29:14];
          fprint_physical_core_id <= fifo_head[13:10];
          cur_region              <= fifo_head[9:6];
          cur_hi                  <= fifo_head[5];
          cur_cs                  <= fifo_head[4];
          fprint_task_id          <= fifo_head[3:0];
          state                   <= DECODE;
        end
        DECODE: begin
          cur_core <= fprint_logical_core_id;
          state    <= IDLE;
          if (core_valid) begin
            if (cur_region == CS_OFFSET) begin
              state <= REG_WR;
            end else if (cur_region == CRC_OFFSET && sel_checkout[fprint_task_id]) begin
              // Set wins over a same-cycle clear
              if (buf_full) fprint_overflow <= (fprint_overflow & ~fprint_overflow_clear) | core_onehot;
              else          state <= MEM_WR;
            end
          end
        end
        REG_WR: begin
          for (int c = 0; c < NUM_CORES; c++) begin
            if (core_onehot[c]) begin
              if (cur_cs)                               checkout[c][fprint_task_id] <= 1'b1;
              else if (checkout[c][fprint_task_id])     checkin[c][fprint_task_id]  <= 1'b1;
            end
          end
          state <= IDLE;
        end
        MEM_WR: begin
          if (cur_hi) begin
            fprint_count_inc  <= 1'b1;
            fprint_count_core <= cur_core;
            state             <= COUNT;
          end else begin
            state <= IDLE;
          end
        end
        COUNT: begin
          for (int c = 0; c < NUM_CORES; c++) begin
            if (core_onehot[c]) head[c] <= head_inc;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == MEM_WR) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (core_onehot[c]) begin
          if (cur_hi) mem_hi[c][sel_head] <= cur_half;
          else        mem_lo[c][sel_head] <= cur_half;
        end
      end
    end
  end

  // Registered read at each comparator tail; same-slot write returns old data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fprint_rd_data <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        fprint_rd_data[c*32 +: 32] <= {mem_hi[c][comp_tail_pointer[c*PTR_W +: PTR_W]],
                                       mem_lo[c][comp_tail_pointer[c*PTR_W +: PTR_W]]};
      end
    end
  end

  // Masked vote: non-participating cores count as checked in, empty mask never votes
  always_comb begin
    for (int t = 0; t < NUM_TASKS; t++) begin
      checkin_vote[t] = |fprint_nmr_mask;
      for (int c = 0; c < NUM_CORES; c++) begin
        checkin_vote[t] = checkin_vote[t] & (checkin[c][t] | ~fprint_nmr_mask[c]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fprint_checkin <= '0;
    else       fprint_checkin <= checkin_vote;
  end

endmodule

// File: tb/tb_fprint_registers_nmr.sv
// Directed + randomized bench for fprint_registers_nmr against a transaction-level model.
module tb_fprint_registers_nmr;
  localparam int NC = 3;
  localparam int RD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  fprint_address;
  logic        fprint_write;
  logic [31:0] fprint_writedata;
  logic        fprint_waitrequest;
  logic [3:0]  fprint_physical_core_id;
  logic [3:0]  fprint_task_id;
  logic [1:0]  fprint_logical_core_id;
  logic [2:0]  fprint_nmr_mask;
  logic [11:0] comp_tail_pointer;
  logic [95:0] fprint_rd_data;
  logic        fprint_count_inc;
  logic [1:0]  fprint_count_core;
  logic [2:0]  fprint_overflow;
  logic [2:0]  fprint_overflow_clear;
  logic [3:0]  comparator_task_id;
  logic        fprint_reset_task;
  logic        fprint_reset_task_ack;
  logic [15:0] fprint_checkin;

  always #5 clk = ~clk;

  // Physical cores 4..7 map to logical 0..3 (3 is out of range)
  assign fprint_logical_core_id = fprint_physical_core_id[1:0];

  fprint_registers_nmr dut (
    .clk(clk), .reset(reset),
    .fprint_address(fprint_address), .fprint_write(fprint_write),
    .fprint_writedata(fprint_writedata), .fprint_waitrequest(fprint_waitrequest),
    .fprint_physical_core_id(fprint_physical_core_id), .fprint_task_id(fprint_task_id),
    .fprint_logical_core_id(fprint_logical_core_id), .fprint_nmr_mask(fprint_nmr_mask),
    .comp_tail_pointer(comp_tail_pointer), .fprint_rd_data(fprint_rd_data),
    .fprint_count_inc(fprint_count_inc), .fprint_count_core(fprint_count_core),
    .fprint_overflow(fprint_overflow), .fprint_overflow_clear(fprint_overflow_clear),
    .comparator_task_id(comparator_task_id), .fprint_reset_task(fprint_reset_task),
    .fprint_reset_task_ack(fprint_reset_task_ack), .fprint_checkin(fprint_checkin)
  );

  int errors = 0;
  int checks = 0;

  bit [15:0]   m_co [NC];
  bit [15:0]   m_ci [NC];
  int          m_head [NC];
  bit [2:0]    m_ovf;
  logic [31:0] m_mem [NC][RD];
  bit [1:0]    m_known [NC][RD];
  int          m_pulses [4];
  int          dut_pulses [4];
  int          ack_cnt;

  always @(negedge clk) begin
    if (reset === 1'b0 && fprint_count_inc === 1'b1) dut_pulses[fprint_count_core]++;
    if (reset === 1'b0 && fprint_reset_task_ack === 1'b1) ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one accepted write with the block's rules
  function automatic void model_write(input logic [7:0] a, input logic [31:0] d);
    int lc, t, tail;
    lc = int'(a[5:4]);
    t  = int'(d[3:0]);
    if (lc >= NC) return;
    if (a[3:0] == 4'h0) begin
      if (d[4]) m_co[lc][t] = 1'b1;
      else if (m_co[lc][t]) m_ci[lc][t] = 1'b1;
      return;
    end
    if (a[3:0] != 4'h1 || !m_co[lc][t]) return;
    tail = int'(comp_tail_pointer[lc*4 +: 4]);
    if ((m_head[lc] + 1) % RD == tail) begin
      m_ovf[lc] = 1'b1;
      return;
    end
    if (d[5]) begin
      m_mem[lc][m_head[lc]][31:16] = d[31:16];
      m_known[lc][m_head[lc]][1] = 1'b1;
      m_head[lc] = (m_head[lc] + 1) % RD;
      m_pulses[lc]++;
    end else begin
      m_mem[lc][m_head[lc]][15:0] = d[31:16];
      m_known[lc][m_head[lc]][0] = 1'b1;
    end
  endfunction

  function automatic logic [15:0] exp_checkin();
    logic [15:0] v;
    for (int t = 0; t < 16; t++) begin
      v[t] = (fprint_nmr_mask != 3'b000);
      for (int c = 0; c < NC; c++) if (fprint_nmr_mask[c] && !m_ci[c][t]) v[t] = 1'b0;
    end
    return v;
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input bit apply);
    int n;
    n = 0;
    fprint_address   = a;
    fprint_writedata = d;
    fprint_write     = 1'b1;
    @(negedge clk);
    while (fprint_waitrequest !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("write_accept", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    if (apply) model_write(a, d);
  endtask

  task automatic bus_idle_drain(input int cycles);
    fprint_write = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_mem(input int c);
    logic [3:0] saved;
    saved = comp_tail_pointer[c*4 +: 4];
    for (int s = 0; s < RD; s++) begin
      if (m_known[c][s] == 2'b11) begin
        comp_tail_pointer[c*4 +: 4] = 4'(s);
        @(negedge clk);
        @(negedge clk);
        check($sformatf("rd_data_c%0d_s%0d", c, s), 64'(fprint_rd_data[c*32 +: 32]), 64'(m_mem[c][s]));
      end
    end
    comp_tail_pointer[c*4 +: 4] = saved;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_checkin"}, 64'(fprint_checkin), 64'(exp_checkin()));
    check({tag, "_overflow"}, 64'(fprint_overflow), 64'(m_ovf));
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_pulses_c%0d", tag, c), 64'(dut_pulses[c]), 64'(m_pulses[c]));
  endtask

  initial begin
    logic [31:0] r;
    int n;
    reset = 1'b1;
    fprint_address = '0; fprint_write = 1'b0; fprint_writedata = '0;
    fprint_nmr_mask = 3'b111; comp_tail_pointer = '0; fprint_overflow_clear = '0;
    comparator_task_id = '0; fprint_reset_task = 1'b0;
    m_ovf = '0; ack_cnt = 0;
    for (int c = 0; c < NC; c++) begin
      m_co[c] = '0; m_ci[c] = '0; m_head[c] = 0;
      for (int s = 0; s < RD; s++) begin m_mem[c][s] = '0; m_known[c][s] = '0; end
    end
    for (int c = 0; c < 4; c++) begin m_pulses[c] = 0; dut_pulses[c] = 0; end

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_waitrequest", 64'(fprint_waitrequest), 64'd1);
    check("rst_ack", 64'(fprint_reset_task_ack), 64'd0);
    check("rst_count_inc", 64'(fprint_count_inc), 64'd0);
    check("rst_overflow", 64'(fprint_overflow), 64'd0);
    check("rst_checkin", 64'(fprint_checkin), 64'd0);
    check("rst_rd_data", 64'(|fprint_rd_data), 64'd0);
    check("rst_ids", 64'({fprint_physical_core_id, fprint_task_id, 2'(fprint_count_core)}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Checkout task 3 on all cores, then checkin one at a time
    for (int c = 0; c < NC; c++) do_write(8'(8'h40 + 16 * c), 32'h0000_0013, 1'b1);
    for (int c = 0; c < NC; c++) begin
      do_write(8'(8'h40 + 16 * c), 32'h0000_0003, 1'b1);
      fprint_write = 1'b0;
      @(negedge clk);
      check("wr_one_cycle", 64'(fprint_waitrequest), 64'd1);
      bus_idle_drain(30);
      check($sformatf("checkin3_after_%0d", c + 1), 64'(fprint_checkin[3]), 64'(c == NC - 1));
    end

    // Core 1, task 2: one fingerprint in two halves
    do_write(8'h50, 32'h0000_0012, 1'b1);
    do_write(8'h51, 32'hBEEF_0002, 1'b1);
    do_write(8'h51, 32'hDEAD_0022, 1'b1);
    bus_idle_drain(30);
    check("pulse_core1", 64'(dut_pulses[1]), 64'd1);
    check("rd_data_core1", 64'(fprint_rd_data[63:32]), 64'h0000_0000_DEAD_BEEF);

    // Fill core 0 to RAM_DEPTH-1 entries, then overflow
    do_write(8'h40, 32'h0000_0012, 1'b1);
    for (int i = 0; i < 15; i++) begin
      r = $urandom;
      do_write(8'h41, {r[31:16], 16'h0002}, 1'b1);
      do_write(8'h41, {r[15:0], 16'h0022}, 1'b1);
    end
    do_write(8'h41, 32'h1111_0002, 1'b1);
    do_write(8'h41, 32'h2222_0022, 1'b1);
    bus_idle_drain(60);
    check_state("fill");
    check("overflow0_set", 64'(fprint_overflow[0]), 64'd1);
    check_mem(0);
    fprint_overflow_clear = 3'b001;
    @(negedge clk);
    fprint_overflow_clear = 3'b000;
    m_ovf[0] = 1'b0;
    @(negedge clk);
    check("overflow0_cleared", 64'(fprint_overflow), 64'(m_ovf));

    // Head wrap 15 -> 0 once the comparator has consumed entries
    comp_tail_pointer[3:0] = 4'd8;
    for (int i = 0; i < 2; i++) begin
      r = $urandom;
      do_write(8'h41, {r[31:16], 16'h0002}, 1'b1);
      do_write(8'h41, {r[15:0], 16'h0022}, 1'b1);
    end
    bus_idle_drain(40);
    check_state("wrap");
    check_mem(0);

    // Masked vote on task 5
    fprint_nmr_mask = 3'b011;
    do_write(8'h40, 32'h0000_0015, 1'b1);
    do_write(8'h50, 32'h0000_0015, 1'b1);
    do_write(8'h40, 32'h0000_0005, 1'b1);
    do_write(8'h50, 32'h0000_0005, 1'b1);
    bus_idle_drain(40);
    check("mask011_checkin5", 64'(fprint_checkin[5]), 64'd1);
    check_state("mask011");
    fprint_nmr_mask = 3'b000;
    repeat (3) @(negedge clk);
    check("mask0_checkin", 64'(fprint_checkin), 64'd0);
    fprint_nmr_mask = 3'b111;
    repeat (3) @(negedge clk);
    check_state("mask111");

    // Task clear while the FIFO is backed up; the last two writes must land after the clear
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      do_write(8'h51, {r[31:16], 16'h0002}, 1'b1);
      do_write(8'h51, {r[15:0], 16'h0022}, 1'b1);
    end
    do_write(8'h40, 32'h0000_0013, 1'b0);
    do_write(8'h40, 32'h0000_0003, 1'b0);
    fprint_write = 1'b0;
    comparator_task_id = 4'd3;
    fprint_reset_task = 1'b1;
    n = 0;
    @(negedge clk);
    while (fprint_reset_task_ack !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", 64'(fprint_reset_task_ack), 64'd1);
    fprint_reset_task = 1'b0;
    for (int c = 0; c < NC; c++) begin m_co[c][3] = 1'b0; m_ci[c][3] = 1'b0; end
    model_write(8'h40, 32'h0000_0013);
    model_write(8'h40, 32'h0000_0003);
    bus_idle_drain(60);
    check("ack_once", 64'(ack_cnt), 64'd1);
    check("clr_checkin3", 64'(fprint_checkin[3]), 64'd0);
    check_state("clr");
    fprint_nmr_mask = 3'b001;
    repeat (3) @(negedge clk);
    check("clr_then_core0_checkin3", 64'(fprint_checkin[3]), 64'd1);
    fprint_nmr_mask = 3'b111;
    check_mem(1);

    // Discards: no checkout, out-of-range logical core; head of core 2 stays at 0
    do_write(8'h61, 32'h1234_0027, 1'b1);
    do_write(8'h70, 32'h0000_0012, 1'b1);
    do_write(8'h71, 32'hCAFE_0002, 1'b1);
    do_write(8'h71, 32'hF00D_0022, 1'b1);
    bus_idle_drain(30);
    check("discard_pulses_c2", 64'(dut_pulses[2]), 64'd0);
    check("discard_pulses_c3", 64'(dut_pulses[3]), 64'd0);
    do_write(8'h60, 32'h0000_0012, 1'b1);
    do_write(8'h61, 32'h5555_0002, 1'b1);
    do_write(8'h61, 32'hAAAA_0022, 1'b1);
    bus_idle_drain(30);
    check("core2_slot0", 64'(fprint_rd_data[95:64]), 64'h0000_0000_AAAA_5555);
    check_state("discard");

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      r[3:0] = ($urandom_range(0, 1) == 0) ? 4'd2 : 4'd5;
      do_write({4'(4 + $urandom_range(0, 3)), 4'($urandom_range(0, 2))}, r, 1'b1);
    end
    bus_idle_drain(60);
    check_state("rand");
    fprint_nmr_mask = 3'($urandom_range(1, 7));
    repeat (3) @(negedge clk);
    check("rand_mask_checkin", 64'(fprint_checkin), 64'(exp_checkin()));
    for (int c = 0; c < NC; c++) check_mem(c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
